// File: rtl/adpll_pkg.sv
// Shared types, default sizes and saturating code arithmetic for the ADPLL
// DCO loop controller.
package adpll_pkg;

   localparam int CODE_W_DEF  = 7;
   localparam int N_CELLS_DEF = 128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      TRACK  = 2'd2
   } state_t;

   // Direction of the most recent tracking move; NONE until the first move.
   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_t;

   // a + b clamped to the top code.
   function automatic logic [CODE_W_DEF-1:0] sat_add(input logic [CODE_W_DEF-1:0] a,
                                                     input logic [CODE_W_DEF-1:0] b);
      logic [CODE_W_DEF:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CODE_W_DEF] ? {CODE_W_DEF{1'b1}} : s[CODE_W_DEF-1:0];
   endfunction

   // a - b clamped to zero.
   function automatic logic [CODE_W_DEF-1:0] sat_sub(input logic [CODE_W_DEF-1:0] a,
                                                     input logic [CODE_W_DEF-1:0] b);
      return (a < b) ? {CODE_W_DEF{1'b0}} : (a - b);
   endfunction

endpackage

// File: rtl/adpll_dco_ctrl_if.sv
// Control/status bundle between the PFD/modulator side and the DCO loop
// controller. The master drives loop control and PFD decisions; the slave
// (controller) returns the DCO code, thermometer pattern and status flags.
interface adpll_dco_ctrl_if
   import adpll_pkg::*;
#(
   parameter int CODE_W  = CODE_W_DEF,
   parameter int N_CELLS = N_CELLS_DEF
);
   logic               enable;
   logic               pfd_valid;
   logic               pfd_up;
   logic               pfd_dn;
   logic               fsk_en;
   logic               fsk_data;
   logic [CODE_W-1:0]  code;
   logic [N_CELLS-1:0] therm;
   logic               locked;
   logic               busy;

   modport master (
      output enable, pfd_valid, pfd_up, pfd_dn, fsk_en, fsk_data,
      input  code, therm, locked, busy
   );

   modport slave (
      input  enable, pfd_valid, pfd_up, pfd_dn, fsk_en, fsk_data,
      output code, therm, locked, busy
   );
endinterface

// File: rtl/adpll_bin2therm.sv
// Combinational binary-to-thermometer encoder: therm[k] = (k <= bin), so the
// lowest cell is always on and the full code lights every cell.
module adpll_bin2therm
   import adpll_pkg::*;
#(
   parameter int CODE_W  = CODE_W_DEF,
   parameter int N_CELLS = N_CELLS_DEF
) (
   input  logic [CODE_W-1:0]  bin,
   output logic [N_CELLS-1:0] therm
);

   // Each cell compares its own index against the code.
   always_comb begin
      therm = '0;
      for (int k = 0; k < N_CELLS; k++) begin
         therm[k] = (k <= int'(bin));
      end
   end

endmodule

// File: rtl/adpll_dco_ctrl.sv
// ADPLL DCO loop controller: 7-step binary frequency search, then +/-1
// tracking with lock detection, then open-loop binary FSK once locked.
// code and therm are registered from one next-code value so they never skew.
module adpll_dco_ctrl
   import adpll_pkg::*;
#(
   parameter int CODE_W      = CODE_W_DEF,
   parameter int N_CELLS     = N_CELLS_DEF,
   parameter int SEARCH_WAIT = 4,
   parameter int LOCK_CNT    = 8,
   parameter int FSK_DELTA   = 4
) (
   input logic              clk,
   input logic              reset,
   adpll_dco_ctrl_if.slave  bus
);

   localparam int IDX_W  = $clog2(CODE_W);
   localparam int WAIT_W = $clog2(SEARCH_WAIT + 1);
   localparam int LCNT_W = $clog2(LOCK_CNT + 1);

   localparam logic [CODE_W-1:0]  SEARCH_START = {1'b1, {(CODE_W-1){1'b0}}};
   localparam logic [CODE_W-1:0]  ONE          = CODE_W'(1);
   localparam logic [CODE_W-1:0]  DELTA        = CODE_W'(FSK_DELTA);
   localparam logic [IDX_W-1:0]   IDX_TOP      = IDX_W'(CODE_W - 1);
   localparam logic [WAIT_W-1:0]  WAIT_LAST    = WAIT_W'(SEARCH_WAIT - 1);
   localparam logic [LCNT_W-1:0]  LCNT_MAX     = LCNT_W'(LOCK_CNT);
   localparam logic [N_CELLS-1:0] THERM_MIN    = {{(N_CELLS-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   dir_t               dir_q, dir_d, mv;
   logic [CODE_W-1:0]  base_q, base_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic [N_CELLS-1:0] therm_q, therm_d;
   logic               locked_q, locked_d;
   logic               busy_q, busy_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [LCNT_W-1:0]  lcnt_q, lcnt_d, lcnt_inc;
   logic               up_req, dn_req, fsk_active;

   // A decision only counts on a strobe and only when it is unambiguous.
   assign up_req     = bus.pfd_valid & bus.pfd_up & ~bus.pfd_dn;
   assign dn_req     = bus.pfd_valid & bus.pfd_dn & ~bus.pfd_up;
   // locked is only ever set in TRACK, so this also implies TRACK.
   assign fsk_active = locked_q & bus.fsk_en;
   assign lcnt_inc   = (lcnt_q == LCNT_MAX) ? lcnt_q : lcnt_q + 1'b1;

   // Next-state, search/track/FSK datapath and status flags.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      base_d   = base_q;
      code_d   = code_q;
      locked_d = locked_q;
      busy_d   = busy_q;
      idx_d    = idx_q;
      wait_d   = wait_q;
      lcnt_d   = lcnt_q;
      mv       = DIR_NONE;

      if (!bus.enable) begin
         // Leaving the loop freezes the DCO where it is; code is not touched.
         state_d  = IDLE;
         dir_d    = DIR_NONE;
         locked_d = 1'b0;
         busy_d   = 1'b0;
         idx_d    = '0;
         wait_d   = '0;
         lcnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SEARCH;
               base_d  = SEARCH_START;
               code_d  = SEARCH_START;
               idx_d   = IDX_TOP;
               wait_d  = '0;
               busy_d  = 1'b1;
            end
            SEARCH: begin
               if (bus.pfd_valid) begin
                  if (wait_q == WAIT_LAST) begin
                     // Last sample of this step decides the trial bit.
                     wait_d = '0;
                     if (bus.pfd_dn & ~bus.pfd_up) begin
                        base_d[idx_q] = 1'b0;
                     end
                     if (idx_q != '0) begin
                        base_d[idx_q - 1'b1] = 1'b1;
                        idx_d                = idx_q - 1'b1;
                     end else begin
                        state_d = TRACK;
                        busy_d  = 1'b0;
                        dir_d   = DIR_NONE;
                        lcnt_d  = '0;
                     end
                     code_d = base_d;
                  end else begin
                     wait_d = wait_q + 1'b1;
                  end
               end
            end
            TRACK: begin
               if (fsk_active) begin
                  // Open-loop modulation: base and lock state stay frozen.
                  code_d = bus.fsk_data ? sat_add(base_q, DELTA) : sat_sub(base_q, DELTA);
               end else begin
                  if (up_req || dn_req) begin
                     base_d = up_req ? sat_add(base_q, ONE) : sat_sub(base_q, ONE);
                     mv     = up_req ? DIR_UP : DIR_DN;
                     dir_d  = mv;
                     if (mv == dir_q) begin
                        // Two moves the same way: still slewing, not locked.
                        lcnt_d   = '0;
                        locked_d = 1'b0;
                     end else begin
                        lcnt_d   = lcnt_inc;
                        locked_d = (lcnt_inc == LCNT_MAX);
                     end
                  end else if (bus.pfd_valid) begin
                     lcnt_d   = lcnt_inc;
                     locked_d = (lcnt_inc == LCNT_MAX);
                  end
                  code_d = base_d;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   adpll_bin2therm #(
      .CODE_W  (CODE_W),
      .N_CELLS (N_CELLS)
   ) u_bin2therm (
      .bin   (code_d),
      .therm (therm_d)
   );

   // State and output registers; reset restores power-on values everywhere.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         dir_q    <= DIR_NONE;
         base_q   <= '0;
         code_q   <= '0;
         therm_q  <= THERM_MIN;
         locked_q <= 1'b0;
         busy_q   <= 1'b0;
         idx_q    <= '0;
         wait_q   <= '0;
         lcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         base_q   <= base_d;
         code_q   <= code_d;
         therm_q  <= therm_d;
         locked_q <= locked_d;
         busy_q   <= busy_d;
         idx_q    <= idx_d;
         wait_q   <= wait_d;
         lcnt_q   <= lcnt_d;
      end
   end

   assign bus.code   = code_q;
   assign bus.therm  = therm_q;
   assign bus.locked = locked_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_adpll_dco_ctrl.sv
// Directed bench for adpll_dco_ctrl: expected outputs are queued when a
// stimulus step is driven and popped/compared one cycle later.
module tb_adpll_dco_ctrl;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   adpll_dco_ctrl_if bus ();

   adpll_dco_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string      tag;
      logic [6:0] code;
      logic       locked;
      logic       busy;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic logic [127:0] therm_of(input logic [6:0] c);
      logic [127:0] ones;
      ones = '1;
      return ones >> (7'd127 - c);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input string tag, input int c, input bit l, input bit b);
      exp_t e;
      e.tag    = tag;
      e.code   = 7'(c);
      e.locked = l;
      e.busy   = b;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         $error("FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         cmp({e.tag, ".code"},   {121'd0, bus.code}, {121'd0, e.code});
         cmp({e.tag, ".therm"},  bus.therm,          therm_of(e.code));
         cmp({e.tag, ".locked"}, {127'd0, bus.locked}, {127'd0, e.locked});
         cmp({e.tag, ".busy"},   {127'd0, bus.busy},   {127'd0, e.busy});
      end
   endtask

   task automatic step_chk(input string tag, input int c, input bit l, input bit b);
      push(tag, c, l, b);
      tick();
      check_out();
   endtask

   task automatic pulse(input bit up, input bit dn);
      bus.pfd_valid = 1'b1;
      bus.pfd_up    = up;
      bus.pfd_dn    = dn;
      tick();
      bus.pfd_valid = 1'b0;
      bus.pfd_up    = 1'b0;
      bus.pfd_dn    = 1'b0;
   endtask

   task automatic pulse_chk(input bit up, input bit dn, input string tag,
                            input int c, input bit l, input bit b);
      bus.pfd_valid = 1'b1;
      bus.pfd_up    = up;
      bus.pfd_dn    = dn;
      push(tag, c, l, b);
      tick();
      bus.pfd_valid = 1'b0;
      bus.pfd_up    = 1'b0;
      bus.pfd_dn    = 1'b0;
      check_out();
   endtask

   // Behavioural PFD around a target code; 28 strobes, one idle cycle apart.
   task automatic run_search(input int target, input string tag);
      bit up, dn;
      for (int i = 1; i <= 28; i++) begin
         up = int'(bus.code) < target;
         dn = int'(bus.code) > target;
         if (i == 27)
            pulse_chk(up, dn, {tag, "_p27"}, (target & 8'h7E) | 1, 1'b0, 1'b1);
         else if (i == 28)
            pulse_chk(up, dn, {tag, "_done"}, target, 1'b0, 1'b0);
         else
            pulse(up, dn);
         tick();
      end
   endtask

   // Alternate up/dn from a fresh TRACK entry; locks on the 8th sample.
   task automatic alt_lock(input int base, input string tag);
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0)
            pulse_chk(1'b1, 1'b0, $sformatf("%s_%0d", tag, i), base + 1, i == 7, 1'b0);
         else
            pulse_chk(1'b0, 1'b1, $sformatf("%s_%0d", tag, i), base, i == 7, 1'b0);
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.enable    = 1'b0;
      bus.pfd_valid = 1'b0;
      bus.pfd_up    = 1'b0;
      bus.pfd_dn    = 1'b0;
      bus.fsk_en    = 1'b0;
      bus.fsk_data  = 1'b0;

      tick();
      step_chk("reset", 0, 1'b0, 1'b0);
      reset = 1'b0;
      step_chk("idle_hold", 0, 1'b0, 1'b0);

      bus.enable = 1'b1;
      step_chk("search_start", 64, 1'b0, 1'b1);
      run_search(45, "s45");

      alt_lock(45, "lock45");

      bus.fsk_en   = 1'b1;
      bus.fsk_data = 1'b1;
      step_chk("fsk_hi", 49, 1'b1, 1'b0);
      bus.fsk_data = 1'b0;
      step_chk("fsk_lo", 41, 1'b1, 1'b0);
      pulse_chk(1'b1, 1'b0, "fsk_ign_up", 41, 1'b1, 1'b0);
      pulse_chk(1'b0, 1'b1, "fsk_ign_dn", 41, 1'b1, 1'b0);
      bus.fsk_en = 1'b0;
      step_chk("fsk_off", 45, 1'b1, 1'b0);

      pulse_chk(1'b1, 1'b0, "unlock_up1", 46, 1'b1, 1'b0);
      pulse_chk(1'b1, 1'b0, "unlock_up2", 47, 1'b0, 1'b0);

      bus.enable = 1'b0;
      step_chk("disable_hold", 47, 1'b0, 1'b0);
      bus.enable = 1'b1;
      step_chk("restart", 64, 1'b0, 1'b1);
      run_search(127, "s127");
      pulse_chk(1'b1, 1'b0, "sat_hi1", 127, 1'b0, 1'b0);
      pulse_chk(1'b1, 1'b0, "sat_hi2", 127, 1'b0, 1'b0);

      bus.enable = 1'b0;
      step_chk("disable2", 127, 1'b0, 1'b0);
      bus.enable = 1'b1;
      step_chk("restart2", 64, 1'b0, 1'b1);
      run_search(0, "s0");
      pulse_chk(1'b0, 1'b1, "sat_lo1", 0, 1'b0, 1'b0);
      pulse_chk(1'b0, 1'b1, "sat_lo2", 0, 1'b0, 1'b0);

      bus.enable = 1'b0;
      step_chk("disable3", 0, 1'b0, 1'b0);
      bus.enable = 1'b1;
      step_chk("restart3", 64, 1'b0, 1'b1);
      run_search(2, "s2");
      alt_lock(2, "lock2");
      bus.fsk_en   = 1'b1;
      bus.fsk_data = 1'b0;
      step_chk("fsk_sat_lo", 0, 1'b1, 1'b0);
      bus.fsk_data = 1'b1;
      step_chk("fsk_b2_hi", 6, 1'b1, 1'b0);

      bus.fsk_en = 1'b0;
      bus.enable = 1'b0;
      step_chk("disable4", 6, 1'b0, 1'b0);
      bus.enable = 1'b1;
      step_chk("restart4", 64, 1'b0, 1'b1);
      for (int i = 1; i <= 9; i++) begin
         if (i == 8)
            pulse_chk(1'b1, 1'b0, "mid_step2", 112, 1'b0, 1'b1);
         else
            pulse(1'b1, 1'b0);
      end
      reset = 1'b1;
      step_chk("reset_mid", 0, 1'b0, 1'b0);
      reset = 1'b0;
      step_chk("after_reset", 64, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
